matrix_op_sequencer: RTL and testbench

//  Instruction-driven controller for the matrix coprocessor. Accepts one 32-bit

---
 rtl/matrix_pkg.sv | 52 +++++
 rtl/matrix_instr_decode.sv | 29 ++
 rtl/matrix_op_sequencer.sv | 175 +++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix coprocessor instruction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: opcode values, instruction field positions, FSM state encoding
// and the decoded-instruction struct passed from the decoder to the sequencer.
package matrix_pkg;

    // Opcodes carried in instr[1:0]
    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_BAD = 2'b10;
    localparam logic [1:0] OP_TRN = 2'b11;

    // Instruction field layout
    localparam int INSTR_W    = 32;
    localparam int OP_LSB     = 0;
    localparam int OP_W       = 2;
    localparam int ADDR_W     = 8;
    localparam int ADDR_A_LSB = 2;
    localparam int ADDR_B_LSB = 10;
    localparam int ADDR_C_LSB = 18;
    localparam int USED_W     = ADDR_C_LSB + ADDR_W;

    // Datapath width and shared wait-counter width
    localparam int MAT_W = 256;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic [ADDR_W-1:0] addr_c;
        logic              is_illegal;
        logic              needs_b;
    } dec_t;

    // Only sum and sub consume a second operand.
    function automatic logic op_needs_b(input logic [OP_W-1:0] op);
        return (op == OP_SUM) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/matrix_instr_decode.sv
// Splits a 32-bit instruction word into opcode, addresses and op class flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input word.
//
// Ports:
//   instr  in   32-bit instruction word
//   dec    out  decoded fields (op, addr_a/b/c, is_illegal, needs_b)
module matrix_instr_decode
    import matrix_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec
);

    // Top bits carry no meaning for this coprocessor.
    logic [INSTR_W-USED_W-1:0] unused_hi;
    assign unused_hi = instr[INSTR_W-1:USED_W];

    always_comb begin
        dec            = '0;
        dec.op         = instr[OP_LSB     +: OP_W];
        dec.addr_a     = instr[ADDR_A_LSB +: ADDR_W];
        dec.addr_b     = instr[ADDR_B_LSB +: ADDR_W];
        dec.addr_c     = instr[ADDR_C_LSB +: ADDR_W];
        dec.is_illegal = (dec.op == OP_BAD);
        dec.needs_b    = op_needs_b(dec.op);
    end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequences one matrix op: read A (and B), run datapath, write result to RAM.
// Latency: accept->done = 3 + (RD_LAT+1)*reads + ALU_LAT; illegal op = 1 cycle.
// Backpressure: instr_ready only in IDLE; offers while busy are dropped, not queued.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   instr_valid/instr   instruction offer; instr_ready = accept window
//   ram_address/wren/wdata  registered RAM controls; ram_rdata read data
//   op_sel/mat_a/mat_b  operands and select to the datapath; alu_result back
//   busy/done/err       status; err qualifies done (illegal opcode)
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter int ALU_LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  ram_address,
    output logic               ram_wren,
    output logic [MAT_W-1:0]   ram_wdata,
    input  logic [MAT_W-1:0]   ram_rdata,
    output logic [OP_W-1:0]    op_sel,
    output logic [MAT_W-1:0]   mat_a,
    output logic [MAT_W-1:0]   mat_b,
    input  logic [MAT_W-1:0]   alu_result,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t            state;
    state_t            next_state;
    dec_t              dec;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [ADDR_W-1:0] addr_c_q;
    logic              needs_b_q;
    logic              err_q;

    logic accept;
    logic cnt_zero;
    logic rd_a_last;
    logic rd_b_last;
    logic exec_last;
    logic in_wait;

    matrix_instr_decode u_decode (
        .instr (instr),
        .dec   (dec)
    );

    assign accept    = instr_valid & instr_ready;
    assign cnt_zero  = (cnt == '0);
    assign rd_a_last = (state == ST_RD_A) && cnt_zero;
    assign rd_b_last = (state == ST_RD_B) && cnt_zero;
    assign exec_last = (state == ST_EXEC) && cnt_zero;
    assign in_wait   = (state == ST_RD_A) || (state == ST_RD_B) || (state == ST_EXEC);
    assign op_sel    = op_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and status outputs
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held low during reset so nothing is offered a ready it cannot see.
                instr_ready = ~rst;
                if (instr_valid && !rst) begin
                    next_state = dec.is_illegal ? ST_DONE : ST_RD_A;
                end
            end
            ST_RD_A: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    next_state = needs_b_q ? ST_RD_B : ST_EXEC;
                end
            end
            ST_RD_B: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_WR;
                end
            end
            ST_WR: begin
                busy       = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                err        = err_q;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. One down-counter times every wait: loaded with
    // RD_LAT for each read (RD_LAT+1 cycles of stable address) and with
    // ALU_LAT for the execute settle window. The RAM address is registered,
    // so each phase loads the next address on the edge that enters it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op_q        <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            needs_b_q   <= 1'b0;
            err_q       <= 1'b0;
            ram_address <= '0;
            ram_wren    <= 1'b0;
            ram_wdata   <= '0;
            mat_a       <= '0;
            mat_b       <= '0;
        end else begin
            // Write strobe lives exactly for the WR cycle.
            ram_wren <= exec_last;

            if (accept) begin
                op_q      <= dec.op;
                addr_b_q  <= dec.addr_b;
                addr_c_q  <= dec.addr_c;
                needs_b_q <= dec.needs_b;
                err_q     <= dec.is_illegal;
                cnt       <= CNT_W'(RD_LAT);
                // Illegal ops must not touch the RAM interface at all.
                if (!dec.is_illegal) begin
                    ram_address <= dec.addr_a;
                end
            end else if (rd_a_last) begin
                mat_a <= ram_rdata;
                if (needs_b_q) begin
                    ram_address <= addr_b_q;
                    cnt         <= CNT_W'(RD_LAT);
                end else begin
                    cnt <= CNT_W'(ALU_LAT);
                end
            end else if (rd_b_last) begin
                mat_b <= ram_rdata;
                cnt   <= CNT_W'(ALU_LAT);
            end else if (exec_last) begin
                ram_wdata   <= alu_result;
                ram_address <= addr_c_q;
            end else if (in_wait) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
module tb_matrix_op_sequencer;

    logic         clk;
    logic         rst;
    logic         instr_valid;
    logic [31:0]  instr;
    logic         instr_ready;
    logic [7:0]   ram_address;
    logic         ram_wren;
    logic [255:0] ram_wdata;
    logic [255:0] ram_rdata;
    logic [1:0]   op_sel;
    logic [255:0] mat_a;
    logic [255:0] mat_b;
    logic [255:0] alu_result;
    logic         busy;
    logic         done;
    logic         err;

    int n_chk;
    int n_err;
    int overlap;

    // Environment RAM (RD_LAT = 2) and reference copy of its expected contents
    logic [255:0] mem     [256];
    logic [255:0] exp_mem [256];
    logic [255:0] rd_pipe;
    logic [255:0] model_b;

    matrix_op_sequencer #(.RD_LAT(2), .ALU_LAT(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .op_sel      (op_sel),
        .mat_a       (mat_a),
        .mat_b       (mat_b),
        .alu_result  (alu_result),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_pipe   <= mem[ram_address];
        ram_rdata <= rd_pipe;
        if (ram_wren) mem[ram_address] <= ram_wdata;
    end

    // Matrix datapath: 4x4 of 16-bit elements, element (r,c) at index r*4+c.
    function automatic logic [255:0] alu_f(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (op)
                2'b00: r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
                2'b01: r[i*16 +: 16] = a[i*16 +: 16] - b[i*16 +: 16];
                2'b11: r[i*16 +: 16] = a[((i % 4) * 4 + (i / 4)) * 16 +: 16];
                default: r[i*16 +: 16] = 16'h0;
            endcase
        end
        return r;
    endfunction

    always_comb alu_result = alu_f(op_sel, mat_a, mat_b);

    always @(negedge clk) if (busy && instr_ready) overlap++;

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic compare_mem(input string tag);
        int nmis;
        nmis = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) nmis++;
        chk(tag, nmis, 0);
    endtask

    // Issue one instruction and check timing, write behaviour and RAM result.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input bit chk_no_b);
        int done_cyc, wren_cnt, exp_cyc;
        logic err_seen, b_touched, legal;
        logic [7:0] wr_addr;
        logic [255:0] exp_a;
        legal    = (op != 2'b10);
        exp_a    = exp_mem[a];
        if (op == 2'b00 || op == 2'b01) model_b = exp_mem[b];
        exp_cyc  = (op == 2'b10) ? 1 : (op == 2'b11) ? 6 : 9;
        done_cyc = -1;
        wren_cnt = 0;
        err_seen = 1'b0;
        b_touched = 1'b0;
        wr_addr  = 8'h00;
        wait_ready();
        instr       = {6'($urandom), c, b, a, op};
        instr_valid = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                instr_valid = 1'b0;
                instr       = $urandom;
            end
            if (ram_wren) begin
                wren_cnt++;
                wr_addr = ram_address;
            end
            if (ram_address == b) b_touched = 1'b1;
            if (done) begin
                done_cyc = cyc;
                err_seen = err;
                break;
            end
        end
        if (legal) exp_mem[c] = alu_f(op, exp_a, model_b);
        chk("done_cycle", done_cyc, exp_cyc);
        chk("err", err_seen, !legal);
        chk("wren_count", wren_cnt, legal ? 1 : 0);
        chk("op_sel", op_sel, op);
        if (legal) begin
            chk("wr_addr", wr_addr, c);
            chk("ram_c", mem[c], exp_mem[c]);
            chk("mat_a", mat_a, exp_a);
            chk("mat_b", mat_b, model_b);
        end
        if (chk_no_b) chk("no_b_access", b_touched, 0);
        compare_mem("ram_all");
    endtask

    initial begin
        int acc[$];
        int dn[$];
        int v;
        logic [1:0] rop;
        n_chk = 0; n_err = 0; overlap = 0;
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        model_b = '0;
        for (int i = 0; i < 256; i++) begin
            logic [255:0] r;
            r = rnd256();
            mem[i] <= r;
            exp_mem[i] = r;
        end
        mem[1] <= {32{8'h03}}; exp_mem[1] = {32{8'h03}};
        mem[2] <= {32{8'h01}}; exp_mem[2] = {32{8'h01}};
        #12;
        chk("rst_ready", instr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {ram_wren, done, err, op_sel, ram_address}, 0);
        chk("rst_mats", mat_a | mat_b | ram_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", instr_ready, 1);

        // Directed: sum, sub, in-place transpose, illegal
        run_op(2'b00, 8'd1, 8'd2, 8'd3, 1'b0);
        chk("sum_const", mem[3], {32{8'h04}});
        run_op(2'b01, 8'd1, 8'd2, 8'd4, 1'b0);
        chk("sub_const", mem[4], {32{8'h02}});
        run_op(2'b11, 8'd5, 8'd2, 8'd5, 1'b1);
        run_op(2'b10, 8'd9, 8'd10, 8'd11, 1'b0);

        // instr_valid held high across two ops
        wait_ready();
        instr = {6'd0, 8'd6, 8'd2, 8'd1, 2'b00};
        instr_valid = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (acc.size() == 2) instr_valid = 1'b0;
            if (instr_valid && instr_ready) acc.push_back(k);
            if (done) dn.push_back(k);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        exp_mem[6] = alu_f(2'b00, exp_mem[1], exp_mem[2]);
        model_b = exp_mem[2];
        chk("hold_accepts", acc.size(), 2);
        v = (acc.size() > 1) ? acc[1] : -1;
        chk("hold_second_accept", v, 10);
        chk("hold_dones", dn.size(), 2);
        v = (dn.size() > 1) ? dn[1] : -1;
        chk("hold_second_done", v, 19);
        chk("hold_ram6", mem[6], exp_mem[6]);

        // Reset asserted during the WR cycle
        mem[7] <= {16{16'hdead}};
        exp_mem[7] = {16{16'hdead}};
        wait_ready();
        instr = {6'd0, 8'd7, 8'd2, 8'd1, 2'b00};
        instr_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
        chk("wr_wren", ram_wren, 1);
        chk("wr_addr7", ram_address, 7);
        rst = 1'b1;
        #1;
        chk("rst_wr_wren", ram_wren, 0);
        chk("rst_wr_status", {busy, done, err, instr_ready}, 0);
        chk("rst_wr_regs", mat_a | mat_b | ram_wdata, 0);
        model_b = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wr_ready", instr_ready, 1);
        chk("rst_wr_ram7", mem[7], exp_mem[7]);
        run_op(2'b00, 8'd1, 8'd2, 8'd7, 1'b0);

        // Address 0 used for every operand
        run_op(2'b01, 8'd0, 8'd0, 8'd0, 1'b0);

        // Randomized ops over a small address window
        for (int n = 0; n < 20; n++) begin
            rop = 2'($urandom_range(0, 3));
            run_op(rop, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                   8'($urandom_range(0, 15)), 1'b0);
        end

        chk("ready_busy_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
